// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Receiving end of the board clock/reset pair. Asserts all downstream
//   resets immediately on the raw asynchronous reset, synchronises its
//   release, holds for HOLD_CYCLES, then releases reset_out[0..N-1] in index
//   order, STAGGER cycles apart. A synchronous soft request re-runs the
//   sequence without touching the raw reset path.
// Ports
//   clock            : single clock domain
//   reset            : raw asynchronous active-high reset
//   soft_reset_req   : synchronous re-sequence request, sampled every rising edge
//   reset_out        : per-subsystem active-high resets, thermometer-shaped
//   reset_done       : high once every reset_out bit is low (RUN state)
//   soft_reset_count : number of accepted soft requests, saturating
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int NUM_OUTPUTS = 3,
    parameter int STAGGER     = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   soft_reset_req,
    output logic [NUM_OUTPUTS-1:0] reset_out,
    output logic                   reset_done,
    output logic [CNT_WIDTH-1:0]   soft_reset_count
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int STG_W  = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER - 1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [STG_W-1:0]       stg_cnt_q, stg_cnt_d;
    logic [NUM_OUTPUTS-1:0] reset_out_q, reset_out_d;
    logic                   reset_done_q, reset_done_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;

    logic                   rst_sync;
    logic [NUM_OUTPUTS-1:0] out_next;

    assign rst_sync = sync_q[SYNC_STAGES-1];

    // reset_out is always thermometer-shaped (all-ones, then zeros from the
    // bottom), so releasing the next index is a left shift with zero fill;
    // the sequence is complete when the shift leaves nothing set. This
    // replaces an explicit release index.
    assign out_next = reset_out_q << 1;

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], 1'b0};
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        stg_cnt_d    = stg_cnt_q;
        reset_out_d  = reset_out_q;
        reset_done_d = reset_done_q;
        count_d      = count_q;

        if (soft_reset_req) begin
            // Accepted in any state; a held request keeps the sequence frozen
            // at its start and counts once per edge.
            state_d      = S_HOLD;
            hold_cnt_d   = '0;
            stg_cnt_d    = '0;
            reset_out_d  = '1;
            reset_done_d = 1'b0;
            if (count_q != '1) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (rst_sync) begin
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        reset_out_d = out_next;
                        hold_cnt_d  = '0;
                        stg_cnt_d   = '0;
                        if (out_next == '0) begin
                            reset_done_d = 1'b1;
                            state_d      = S_RUN;
                        end else begin
                            state_d = S_RELEASE;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (stg_cnt_q == STG_LAST) begin
                        reset_out_d = out_next;
                        stg_cnt_d   = '0;
                        if (out_next == '0) begin
                            reset_done_d = 1'b1;
                            state_d      = S_RUN;
                        end
                    end else begin
                        stg_cnt_d = stg_cnt_q + STG_W'(1);
                    end
                end
                S_RUN: begin
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q       <= '1;
            state_q      <= S_HOLD;
            hold_cnt_q   <= '0;
            stg_cnt_q    <= '0;
            reset_out_q  <= '1;
            reset_done_q <= 1'b0;
            count_q      <= '0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            stg_cnt_q    <= stg_cnt_d;
            reset_out_q  <= reset_out_d;
            reset_done_q <= reset_done_d;
            count_q      <= count_d;
        end
    end

    assign reset_out        = reset_out_q;
    assign reset_done       = reset_done_q;
    assign soft_reset_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Directed bench for reset_sequencer. Three instances share clock and raw
//   reset: defaults, a 2-bit saturating counter variant, and a single-output
//   HOLD=1/STAGGER=1 variant. Outputs are sampled 1 ns after each rising edge.
module tb_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req   = 1'b0;
    logic       req_s = 1'b0;
    logic       req_o = 1'b0;

    logic [2:0] out;
    logic       done;
    logic [7:0] cnt;
    logic [2:0] out_s;
    logic       done_s;
    logic [1:0] cnt_s;
    logic [0:0] out_o;
    logic       done_o;
    logic [7:0] cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    reset_sequencer dut (
        .clock(clock), .reset(reset), .soft_reset_req(req),
        .reset_out(out), .reset_done(done), .soft_reset_count(cnt)
    );

    reset_sequencer #(.CNT_WIDTH(2)) dut_s (
        .clock(clock), .reset(reset), .soft_reset_req(req_s),
        .reset_out(out_s), .reset_done(done_s), .soft_reset_count(cnt_s)
    );

    reset_sequencer #(.NUM_OUTPUTS(1), .HOLD_CYCLES(1), .STAGGER(1)) dut_o (
        .clock(clock), .reset(reset), .soft_reset_req(req_o),
        .reset_out(out_o), .reset_done(done_o), .soft_reset_count(cnt_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advance edges first..last (relative to a start edge) and check the
    // default instance: bit i releases at rel0 + 2*i, done with the last.
    // With raw set, also check the single-output instance, which releases at E3.
    task automatic seq_check(input string tag, input int first, input int last,
                             input int rel0, input int exp_cnt, input bit raw);
        logic [2:0] exp_out;
        for (int j = first; j <= last; j++) begin
            tick();
            if (j < rel0)          exp_out = 3'b111;
            else if (j < rel0 + 2) exp_out = 3'b110;
            else if (j < rel0 + 4) exp_out = 3'b100;
            else                   exp_out = 3'b000;
            check_eq($sformatf("%s_e%0d_out", tag, j), 32'(out), 32'(exp_out));
            check_eq($sformatf("%s_e%0d_done", tag, j), 32'(done), 32'(j >= rel0 + 4));
            check_eq($sformatf("%s_e%0d_cnt", tag, j), 32'(cnt), 32'(exp_cnt));
            if (raw) begin
                check_eq($sformatf("%s_e%0d_out1", tag, j), 32'(out_o), 32'(j < 3));
                check_eq($sformatf("%s_e%0d_done1", tag, j), 32'(done_o), 32'(j >= 3));
            end
        end
    endtask

    initial begin
        // Raw reset asserted with no clock edge yet.
        #1 reset = 1'b1;
        #1;
        check_eq("async_out", 32'(out), 32'h7);
        check_eq("async_done", 32'(done), 32'h0);
        check_eq("async_cnt", 32'(cnt), 32'h0);

        // Test 1: reset held 10 cycles, released between edges.
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("inrst_out", 32'(out), 32'h7);
        end
        reset = 1'b0;
        seq_check("t1", 1, 12, 6, 0, 1'b1);

        // Test 2: single-cycle soft pulse in RUN.
        req = 1'b1;
        tick();
        req = 1'b0;
        check_eq("t2_e0_out", 32'(out), 32'h7);
        check_eq("t2_e0_done", 32'(done), 32'h0);
        check_eq("t2_e0_cnt", 32'(cnt), 32'h1);
        seq_check("t2", 1, 9, 4, 1, 1'b0);

        // Held request: counted per edge, sequence frozen at start.
        req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("held_out", 32'(out), 32'h7);
            check_eq("held_cnt", 32'(cnt), 32'(2 + k));
        end
        req = 1'b0;
        seq_check("held", 1, 8, 4, 4, 1'b0);

        // Test 4: asynchronous raw pulse in RUN, no edge inside it.
        #3 reset = 1'b1;
        #1;
        check_eq("t4_async_out", 32'(out), 32'h7);
        check_eq("t4_async_done", 32'(done), 32'h0);
        check_eq("t4_async_cnt", 32'(cnt), 32'h0);
        check_eq("t4_async_out1", 32'(out_o), 32'h1);
        #1 reset = 1'b0;
        seq_check("t4", 1, 10, 6, 0, 1'b1);

        // Test 3: second pulse mid-RELEASE restarts the sequence.
        req = 1'b1;
        tick();
        req = 1'b0;
        check_eq("t3_e0_cnt", 32'(cnt), 32'h1);
        seq_check("t3a", 1, 4, 4, 1, 1'b0);
        req = 1'b1;
        tick();
        req = 1'b0;
        check_eq("t3_e5_out", 32'(out), 32'h7);
        check_eq("t3_e5_cnt", 32'(cnt), 32'h2);
        seq_check("t3b", 1, 9, 4, 2, 1'b0);

        // Test 5: 2-bit counter saturates at 3.
        for (int p = 1; p <= 5; p++) begin
            req_s = 1'b1;
            tick();
            req_s = 1'b0;
            check_eq($sformatf("t5_p%0d_cnt", p), 32'(cnt_s), 32'((p < 3) ? p : 3));
            check_eq($sformatf("t5_p%0d_out", p), 32'(out_s), 32'h7);
            for (int k = 0; k < 8; k++) tick();
            check_eq($sformatf("t5_p%0d_endout", p), 32'(out_s), 32'h0);
            check_eq($sformatf("t5_p%0d_done", p), 32'(done_s), 32'h1);
        end

        // Test 6: single output, soft pulse releases one edge later.
        req_o = 1'b1;
        tick();
        req_o = 1'b0;
        check_eq("t6_e0_out", 32'(out_o), 32'h1);
        check_eq("t6_e0_done", 32'(done_o), 32'h0);
        check_eq("t6_e0_cnt", 32'(cnt_o), 32'h1);
        tick();
        check_eq("t6_e1_out", 32'(out_o), 32'h0);
        check_eq("t6_e1_done", 32'(done_o), 32'h1);

        // Raw reset and soft request present at the same edge: raw wins.
        reset = 1'b1;
        req   = 1'b1;
        tick();
        check_eq("both_cnt", 32'(cnt), 32'h0);
        check_eq("both_out", 32'(out), 32'h7);
        check_eq("both_done", 32'(done), 32'h0);
        req   = 1'b0;
        reset = 1'b0;
        seq_check("both", 1, 10, 6, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
